// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StArmed    = 2'd1,
    StRinging  = 2'd2,
    StSnoozing = 2'd3
  } alarm_state_e;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Clearable free-running up-counter; expire_o flags the terminal count.
module alarm_timer #(
  parameter int unsigned Width    = 6,
  parameter int unsigned Terminal = 59
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [Width-1:0] TermCnt = Width'(Terminal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clr_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == TermCnt);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, trigger compare, ring/snooze FSM.
// Define ALARM_BLINK_EN for a pulsed buzzer while ringing.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned SNOOZE_SEC   = 300,
  parameter int unsigned MAX_SNOOZE   = 3,
  localparam int unsigned SnzW        = $clog2(MAX_SNOOZE + 1)
) (
  input  logic              clk_1Hz,
  input  logic              reset,
  input  logic [SEC_W-1:0]  seconds,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [HOUR_W-1:0] hours,
  input  logic              alarm_enable,
  input  logic              alarm_set_mode,
  input  logic [MIN_W-1:0]  set_alarm_minutes,
  input  logic [HOUR_W-1:0] set_alarm_hours,
  input  logic              snooze,
  input  logic              stop,
  output logic              alarm_on,
  output logic [MIN_W-1:0]  alarm_minutes,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [SnzW-1:0]   snooze_left,
  output logic [1:0]        state
);

  localparam int unsigned CntW = $clog2(max_u(max_u(RING_TIMEOUT, SNOOZE_SEC), 2));
  localparam logic [SnzW-1:0]   SnzReload = SnzW'(MAX_SNOOZE);
  localparam logic [HOUR_W-1:0] MaxHour   = HOUR_W'(MAX_HOUR);
  localparam logic [MIN_W-1:0]  MaxMin    = MIN_W'(MAX_MIN);

  alarm_state_e      state_q, state_d;
  logic              alarm_on_q, alarm_on_d;
  logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
  logic [HOUR_W-1:0] alarm_hr_q, alarm_hr_d;
  logic [SnzW-1:0]   snooze_left_q, snooze_left_d;

  logic ring_clr, snz_clr;
  logic ring_expire, snz_expire;
  logic set_valid, trigger;

  assign set_valid = (set_alarm_hours <= MaxHour) && (set_alarm_minutes <= MaxMin);
  assign trigger   = (state_q == StArmed) && (hours == alarm_hr_q) &&
                     (minutes == alarm_min_q) && (seconds == '0);

  // Counters hold zero outside their state and restart on every entry.
  assign ring_clr = (state_q != StRinging) || (state_d != StRinging);
  assign snz_clr  = (state_q != StSnoozing) || (state_d != StSnoozing);

  alarm_timer #(
    .Width    (CntW),
    .Terminal (RING_TIMEOUT - 1)
  ) u_ring_timer (
    .clk_i    (clk_1Hz),
    .rst_ni   (reset),
    .clr_i    (ring_clr),
    .expire_o (ring_expire)
  );

  alarm_timer #(
    .Width    (CntW),
    .Terminal (SNOOZE_SEC - 1)
  ) u_snz_timer (
    .clk_i    (clk_1Hz),
    .rst_ni   (reset),
    .clr_i    (snz_clr),
    .expire_o (snz_expire)
  );

  always_comb begin
    state_d       = state_q;
    alarm_min_d   = alarm_min_q;
    alarm_hr_d    = alarm_hr_q;
    snooze_left_d = snooze_left_q;

    if (!alarm_enable) begin
      state_d       = StOff;
      snooze_left_d = SnzReload;
    end else begin
      if (alarm_set_mode && set_valid) begin
        alarm_min_d = set_alarm_minutes;
        alarm_hr_d  = set_alarm_hours;
      end

      if (state_q == StOff) begin
        state_d = StArmed;
      end else if (alarm_set_mode) begin
        state_d       = StArmed;
        snooze_left_d = SnzReload;
      end else if (stop && (state_q != StArmed)) begin
        state_d       = StArmed;
        snooze_left_d = SnzReload;
      end else if (snooze && (state_q == StRinging) && (snooze_left_q != '0)) begin
        state_d       = StSnoozing;
        snooze_left_d = snooze_left_q - 1'b1;
      end else if ((state_q == StRinging) && ring_expire) begin
        state_d       = StArmed;
        snooze_left_d = SnzReload;
      end else if ((state_q == StSnoozing) && snz_expire) begin
        state_d = StRinging;
      end else if (trigger) begin
        state_d = StRinging;
      end
    end
  end

`ifdef ALARM_BLINK_EN
  // On at entry, then toggles each tick while ringing continues.
  assign alarm_on_d = (state_d == StRinging) && (ring_clr || !alarm_on_q);
`else
  assign alarm_on_d = (state_d == StRinging);
`endif

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      state_q       <= StOff;
      alarm_on_q    <= 1'b0;
      alarm_min_q   <= '0;
      alarm_hr_q    <= '0;
      snooze_left_q <= SnzReload;
    end else begin
      state_q       <= state_d;
      alarm_on_q    <= alarm_on_d;
      alarm_min_q   <= alarm_min_d;
      alarm_hr_q    <= alarm_hr_d;
      snooze_left_q <= snooze_left_d;
    end
  end

  assign alarm_on      = alarm_on_q;
  assign alarm_minutes = alarm_min_q;
  assign alarm_hours   = alarm_hr_q;
  assign snooze_left   = snooze_left_q;
  assign state         = state_q;

endmodule
